kbd_portctrl: RTL and testbench
===============================

Name: kbd_portctrl

Overview:
- Successor to the fixed memory/port router: the same bank routing and port registers, plus a parametrised keyboard FIFO in place of the single-byte latch.
- Adds a relocatable port window, an overflow flag and FIFO flush.
- Keyboard capture runs in the CPU clock domain.
- Sits between the AVR core, the SRAM/TEXT/GRPH memories, the PS/2 receiver and the external AT-to-ASCII converter.

Parameters:
KBD_DEPTH, 16, FIFO entries; power of two, 2..256
BANK_BASE, 16'hF000, first address of the banked window
PORT_BASE, 16'h0020, base address of the port register block

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous reset, active-high
address  in  16  CPU data address
wren  in  1  CPU write strobe
rden  in  1  CPU read strobe (one cycle per read)
data_o  in  8  write data from CPU
data_i  out  8  read data to CPU (combinational)
data_o_sram  in  8  SRAM read data
data_o_text  in  8  TEXT read data
data_o_grph  in  8  GRPH read data
data_w_sram  out  1  SRAM write enable
data_w_text  out  1  TEXT write enable
data_w_grph  out  1  GRPH write enable
bank  out  8  bank register
cursor_x  out  8  cursor column
cursor_y  out  8  cursor row
videomode  out  8  video mode register
ps2_data  in  8  PS/2 scancode byte
ps2_hit  in  1  one-cycle strobe, ps2_data valid
kbd_ascii  in  8  converter output for ps2_data/kbd_shift
kbd_shift  out  1  shift state to converter
kbd_irq  out  1  keyboard interrupt (see Optional Feature)

Behaviour:
- Reset: bank, cursor_x, cursor_y, videomode = 0; FIFO empty; overflow = 0; break flag = 0; kbd_shift = 0; irq enable = 0; kbd_irq = 0.
- Routing when address >= BANK_BASE:
  - bank 8'b0000001x: TEXT; data_w_text = wren, data_i = data_o_text.
  - bank 8'b001xxxxx: GRPH; data_w_grph = wren, data_i = data_o_grph.
  - Any other bank: all write enables 0, data_i = 8'hFF.
  - data_w_sram = 0 in all three cases.
- Routing below BANK_BASE:
  - data_w_sram = wren; data_i = data_o_sram.
  - Port reads override data_i; SRAM writes still occur at port addresses.
- Port offsets from PORT_BASE:
  - +0 BANK (rw).
  - +1 KEYB (r: FIFO head, 8'h00 if empty).
  - +2 STATUS.
  - +0x0C CURSX (rw).
  - +0x0D CURSY (rw).
  - +0x18 VIDEO (rw).
  - Register writes take effect at the clock edge with wren.
- STATUS read bits:
  - [7] overflow (sticky).
  - [6] irq enable.
  - [5] full.
  - [4] not empty.
  - [3:0] entry count saturated at 15.
- STATUS write bits:
  - [7] = 1 clears overflow.
  - [6] loads irq enable.
  - [4] = 1 flushes the FIFO (count = 0, pointers reset).
  - Other bits are ignored.
- Pop: rden at KEYB with FIFO not empty advances the read pointer at that edge. The value read that cycle is the pre-pop head.
- Scancode handling on ps2_hit:
  - 8'hF0: set break flag, no push.
  - 8'hE0: ignored, break flag unchanged.
  - 8'h12 or 8'h59: kbd_shift <= ~break.
  - Every non-F0/E0 code: push {break, kbd_ascii[6:0]}, then clear break.
- FIFO full on push: entry dropped, overflow <= 1, existing contents unchanged.
- Simultaneous events:
  - Push and pop in the same cycle: both occur and count is unchanged. This includes the full case, where the push is accepted with no overflow.
  - Push and pop on an empty FIFO: no pop, push succeeds.
  - Flush with a push or pop in the same cycle: flush wins and the push is discarded.
- Count register is clog2(KBD_DEPTH)+1 bits wide; pointers wrap modulo KBD_DEPTH.
- Reset asserted mid-operation returns every output to its reset value immediately, independent of clock.

Optional Feature:
KBD_IRQ_EN
- Defined: kbd_irq is registered and equals (irq enable & not empty) one cycle after either changes.
- Not defined: kbd_irq is tied 0, and STATUS[6] reads 0 and ignores writes.

Test Plan:
- Reset, then write 8'h02 to PORT_BASE+0 and read address 16'hF010 with data_o_text = 8'h41 -> data_i = 8'h41, data_w_text follows wren, data_w_sram = 0. With bank = 8'h80: data_i = 8'hFF and no write enable.
- Send scancodes 8'h1C, 8'hF0, 8'h1C with kbd_ascii = 8'h61 -> STATUS = 8'h12; KEYB reads 8'h61 then 8'hE1; STATUS then 8'h00.
- Push KBD_DEPTH+1 keys -> STATUS[5] = 1, STATUS[7] = 1, count saturated at 15. Write STATUS 8'h80 -> overflow clears. Write 8'h10 -> FIFO empty and KEYB reads 8'h00.
- Full FIFO with ps2_hit and rden at KEYB in the same cycle -> count unchanged, overflow stays 0, new key lands at the tail.
- Send 8'h12, then 8'h1C -> kbd_shift = 1 during the second push. Send 8'hF0, 8'h12 -> kbd_shift = 0.
- With KBD_IRQ_EN: write STATUS 8'h40, push one key -> kbd_irq = 1 next cycle; pop -> kbd_irq = 0 next cycle. Assert reset mid-sequence -> all outputs 0 at once.

Source files
------------

// File: rtl/kbd_portctrl_if.sv
// kbd_portctrl_if: CPU data bus between the AVR core and kbd_portctrl.
interface kbd_portctrl_if;
    logic [15:0] address;
    logic        wren;
    logic        rden;
    logic [7:0]  data_o;
    logic [7:0]  data_i;
    modport master(output address, wren, rden, data_o, input data_i);
    modport slave(input address, wren, rden, data_o, output data_i);
endinterface

// File: rtl/kbd_portctrl.sv
// kbd_portctrl: bank/port router with PS/2 keyboard FIFO; define KBD_IRQ_EN to enable the keyboard interrupt.
module kbd_portctrl #(
    parameter int          KBD_DEPTH = 16,
    parameter logic [15:0] BANK_BASE = 16'hF000,
    parameter logic [15:0] PORT_BASE = 16'h0020
) (
    input  logic           clock,
    input  logic           reset,
    kbd_portctrl_if.slave  cpu,
    input  logic [7:0]     data_o_sram,
    input  logic [7:0]     data_o_text,
    input  logic [7:0]     data_o_grph,
    output logic           data_w_sram,
    output logic           data_w_text,
    output logic           data_w_grph,
    output logic [7:0]     bank,
    output logic [7:0]     cursor_x,
    output logic [7:0]     cursor_y,
    output logic [7:0]     videomode,
    input  logic [7:0]     ps2_data,
    input  logic           ps2_hit,
    input  logic [7:0]     kbd_ascii,
    output logic           kbd_shift,
    output logic           kbd_irq
);
    localparam int AW = (KBD_DEPTH > 1) ? $clog2(KBD_DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [7:0]    bank_q, bank_d, cx_q, cx_d, cy_q, cy_d, vid_q, vid_d;
    logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d, brk_q, brk_d, shift_q, shift_d;
    logic          irq_en_q, irq_en_d, kbd_irq_q, kbd_irq_d;
    logic [7:0]    mem_q [KBD_DEPTH];
    logic          in_bank, is_text, is_grph, empty, full;
    logic          sel_bank, sel_keyb, sel_stat, sel_cx, sel_cy, sel_vid;
    logic          wr_stat, flush, pop, key, push, drop;
    logic [8:0]    cnt9;
    logic [7:0]    status;
    logic          unused_ascii;

    always_comb begin
        in_bank     = cpu.address >= BANK_BASE;
        sel_bank    = !in_bank && cpu.address == PORT_BASE;
        sel_keyb    = !in_bank && cpu.address == PORT_BASE + 16'h01;
        sel_stat    = !in_bank && cpu.address == PORT_BASE + 16'h02;
        sel_cx      = !in_bank && cpu.address == PORT_BASE + 16'h0C;
        sel_cy      = !in_bank && cpu.address == PORT_BASE + 16'h0D;
        sel_vid     = !in_bank && cpu.address == PORT_BASE + 16'h18;
        is_text     = bank_q[7:1] == 7'b0000001;
        is_grph     = bank_q[7:5] == 3'b001;
        data_w_sram = !in_bank && cpu.wren;
        data_w_text = in_bank && is_text && cpu.wren;
        data_w_grph = in_bank && is_grph && cpu.wren;
        empty       = count_q == '0;
        full        = count_q == CW'(KBD_DEPTH);
        cnt9        = 9'(count_q);
        status      = {ovf_q, irq_en_q, full, !empty, (cnt9 > 9'd15) ? 4'hF : cnt9[3:0]};
        cpu.data_i  = in_bank  ? (is_text ? data_o_text : is_grph ? data_o_grph : 8'hFF) :
                      sel_bank ? bank_q :
                      sel_keyb ? (empty ? 8'h00 : mem_q[rptr_q]) :
                      sel_stat ? status :
                      sel_cx   ? cx_q :
                      sel_cy   ? cy_q :
                      sel_vid  ? vid_q : data_o_sram;
        wr_stat     = cpu.wren && sel_stat;
        flush       = wr_stat && cpu.data_o[4];
        pop         = cpu.rden && sel_keyb && !empty;
        key         = ps2_hit && ps2_data != 8'hF0 && ps2_data != 8'hE0;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts
        push        = key && !flush && (!full || pop);
        drop        = key && !flush && full && !pop;
        bank_d      = (cpu.wren && sel_bank) ? cpu.data_o : bank_q;
        cx_d        = (cpu.wren && sel_cx) ? cpu.data_o : cx_q;
        cy_d        = (cpu.wren && sel_cy) ? cpu.data_o : cy_q;
        vid_d       = (cpu.wren && sel_vid) ? cpu.data_o : vid_q;
        rptr_d      = flush ? '0 : rptr_q + AW'(pop);
        wptr_d      = flush ? '0 : wptr_q + AW'(push);
        count_d     = flush ? '0 : count_q + CW'(push) - CW'(pop);
        ovf_d       = drop || (ovf_q && !(wr_stat && cpu.data_o[7]));
        brk_d       = !ps2_hit ? brk_q : (ps2_data == 8'hF0) ? 1'b1 : (ps2_data == 8'hE0) ? brk_q : 1'b0;
        shift_d     = (ps2_hit && (ps2_data == 8'h12 || ps2_data == 8'h59)) ? !brk_q : shift_q;
`ifdef KBD_IRQ_EN
        irq_en_d    = wr_stat ? cpu.data_o[6] : irq_en_q;
`else
        irq_en_d    = 1'b0;
`endif
        kbd_irq_d   = irq_en_q && !empty;
        unused_ascii = kbd_ascii[7];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bank_q    <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            vid_q     <= '0;
            rptr_q    <= '0;
            wptr_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            brk_q     <= 1'b0;
            shift_q   <= 1'b0;
            irq_en_q  <= 1'b0;
            kbd_irq_q <= 1'b0;
        end else begin
            bank_q    <= bank_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            vid_q     <= vid_d;
            rptr_q    <= rptr_d;
            wptr_q    <= wptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            brk_q     <= brk_d;
            shift_q   <= shift_d;
            irq_en_q  <= irq_en_d;
            kbd_irq_q <= kbd_irq_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wptr_q] <= {brk_q, kbd_ascii[6:0]};
    end

    assign bank      = bank_q;
    assign cursor_x  = cx_q;
    assign cursor_y  = cy_q;
    assign videomode = vid_q;
    assign kbd_shift = shift_q;
    assign kbd_irq   = kbd_irq_q;
endmodule

// File: tb/tb_kbd_portctrl.sv
// tb_kbd_portctrl: vector table, directed corner sequences and a queue-model random run for kbd_portctrl.
module tb_kbd_portctrl;
    localparam int D = 16;
    localparam logic [15:0] P_BANK = 16'h0020, P_KEYB = 16'h0021, P_STAT = 16'h0022;
    localparam logic [15:0] P_CX = 16'h002C, P_CY = 16'h002D, P_VID = 16'h0038;

    logic clock = 1'b0, reset = 1'b1;
    logic [7:0] data_o_sram = 8'h53, data_o_text = 8'h41, data_o_grph = 8'h47;
    logic data_w_sram, data_w_text, data_w_grph, kbd_shift, kbd_irq, ps2_hit;
    logic [7:0] bank, cursor_x, cursor_y, videomode, ps2_data, kbd_ascii;
    int n_chk = 0, n_fail = 0;

    kbd_portctrl_if bus();

    kbd_portctrl #(.KBD_DEPTH(D)) dut (
        .clock(clock), .reset(reset), .cpu(bus),
        .data_o_sram(data_o_sram), .data_o_text(data_o_text), .data_o_grph(data_o_grph),
        .data_w_sram(data_w_sram), .data_w_text(data_w_text), .data_w_grph(data_w_grph),
        .bank(bank), .cursor_x(cursor_x), .cursor_y(cursor_y), .videomode(videomode),
        .ps2_data(ps2_data), .ps2_hit(ps2_hit), .kbd_ascii(kbd_ascii),
        .kbd_shift(kbd_shift), .kbd_irq(kbd_irq)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  bnk;
        logic [15:0] addr;
        logic        we;
        logic [7:0]  di;
        logic [2:0]  wtgs;
    } vec_t;
    vec_t tbl[11];

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus.address = a; bus.data_o = d; bus.wren = 1'b1;
        tick();
        bus.wren = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] v);
        bus.address = a; bus.rden = 1'b1;
        #1 v = bus.data_i;
        tick();
        bus.rden = 1'b0;
    endtask

    task automatic key(input logic [7:0] code, input logic [7:0] asc);
        ps2_data = code; kbd_ascii = asc; ps2_hit = 1'b1;
        tick();
        ps2_hit = 1'b0;
    endtask

    logic [7:0] v, exp8;
    int q[$];
    bit m_ovf, m_brk, m_shift, m_ien, m_irq, wr_r, rd_r, hit_r, pop_r;
    logic [7:0] dat_r, code_r, asc_r;

    initial begin
        bus.address = 16'h0100; bus.wren = 1'b0; bus.rden = 1'b0; bus.data_o = 8'h00;
        ps2_hit = 1'b0; ps2_data = 8'h00; kbd_ascii = 8'h00;
        tbl[0]  = '{8'h02, 16'hF010, 1'b1, 8'h41, 3'b100};
        tbl[1]  = '{8'h03, 16'hFFFF, 1'b0, 8'h41, 3'b000};
        tbl[2]  = '{8'h20, 16'hF000, 1'b1, 8'h47, 3'b010};
        tbl[3]  = '{8'h3F, 16'hF123, 1'b1, 8'h47, 3'b010};
        tbl[4]  = '{8'h80, 16'hF010, 1'b1, 8'hFF, 3'b000};
        tbl[5]  = '{8'h01, 16'hF010, 1'b1, 8'hFF, 3'b000};
        tbl[6]  = '{8'h40, 16'hF010, 1'b0, 8'hFF, 3'b000};
        tbl[7]  = '{8'h80, 16'h0100, 1'b1, 8'h53, 3'b001};
        tbl[8]  = '{8'h02, 16'hEFFF, 1'b1, 8'h53, 3'b001};
        tbl[9]  = '{8'h80, P_BANK,   1'b0, 8'h80, 3'b000};
        tbl[10] = '{8'h05, P_CX,     1'b0, 8'h00, 3'b000};
        #12 reset = 1'b0;
        tick();
        check("rst_bank", bank, 8'h00);
        check("rst_cursor", {cursor_x, cursor_y}, 16'h0000);
        check("rst_video", videomode, 8'h00);
        check("rst_shift_irq", {kbd_shift, kbd_irq}, 2'b00);
        rd(P_STAT, v); check("rst_status", v, 8'h00);

        foreach (tbl[i]) begin
            wr(P_BANK, tbl[i].bnk);
            bus.address = tbl[i].addr; bus.wren = tbl[i].we;
            #1;
            check($sformatf("route_di[%0d]", i), bus.data_i, tbl[i].di);
            check($sformatf("route_we[%0d]", i), {data_w_text, data_w_grph, data_w_sram}, tbl[i].wtgs);
            bus.wren = 1'b0;
        end

        wr(P_CX, 8'h11); wr(P_CY, 8'h22); wr(P_VID, 8'h33);
        check("regs_out", {cursor_x, cursor_y}, 16'h1122);
        check("video_out", videomode, 8'h33);
        rd(P_CY, v); check("cursy_read", v, 8'h22);
        rd(P_VID, v); check("video_read", v, 8'h33);

        key(8'h1C, 8'h61); key(8'hF0, 8'h00); key(8'h1C, 8'h61);
        rd(P_STAT, v); check("scan_status", v, 8'h12);
        rd(P_KEYB, v); check("scan_make", v, 8'h61);
        rd(P_KEYB, v); check("scan_break", v, 8'hE1);
        rd(P_STAT, v); check("scan_empty", v, 8'h00);

        for (int i = 0; i <= D; i++) key(8'h1C, 8'h41);
        rd(P_STAT, v); check("ovf_status", v, 8'hBF);
        wr(P_STAT, 8'h80);
        rd(P_STAT, v); check("ovf_clear", v, 8'h3F);
        wr(P_STAT, 8'h10);
        rd(P_STAT, v); check("flush_status", v, 8'h00);
        rd(P_KEYB, v); check("flush_keyb", v, 8'h00);

        for (int i = 0; i < D; i++) key(8'h1C, 8'h30 + 8'(i));
        rd(P_STAT, v); check("full_status", v, 8'h3F);
        ps2_data = 8'h1C; kbd_ascii = 8'h7A; ps2_hit = 1'b1;
        rd(P_KEYB, v); check("full_pp_head", v, 8'h30);
        ps2_hit = 1'b0;
        rd(P_STAT, v); check("full_pp_status", v, 8'h3F);
        rd(P_KEYB, v); check("full_pp_next", v, 8'h31);
        for (int i = 0; i < D - 2; i++) rd(P_KEYB, v);
        rd(P_KEYB, v); check("full_pp_tail", v, 8'h7A);
        rd(P_STAT, v); check("full_pp_drained", v, 8'h00);

        key(8'h12, 8'h00);
        check("shift_make", kbd_shift, 1'b1);
        ps2_data = 8'h1C; kbd_ascii = 8'h41; ps2_hit = 1'b1;
        #1 check("shift_during_push", kbd_shift, 1'b1);
        tick(); ps2_hit = 1'b0;
        key(8'hF0, 8'h00); key(8'h12, 8'h00);
        check("shift_break", kbd_shift, 1'b0);

        wr(P_STAT, 8'h10);
        key(8'h1C, 8'h61);
        ps2_data = 8'h1C; ps2_hit = 1'b1;
        wr(P_STAT, 8'h10);
        ps2_hit = 1'b0;
        rd(P_STAT, v); check("flush_wins", v, 8'h00);

`ifdef KBD_IRQ_EN
        wr(P_STAT, 8'h40);
        key(8'h1C, 8'h61);
        tick(); check("irq_set", kbd_irq, 1'b1);
        rd(P_KEYB, v);
        tick(); check("irq_clear", kbd_irq, 1'b0);
        key(8'h1C, 8'h61);
        tick(); check("irq_reset_pre", kbd_irq, 1'b1);
`else
        wr(P_STAT, 8'h40);
        rd(P_STAT, v); check("ien_ignored", v, 8'h00);
        key(8'h1C, 8'h61);
        tick(); check("irq_tied", kbd_irq, 1'b0);
`endif

        wr(P_BANK, 8'h05); wr(P_CX, 8'h07); key(8'h12, 8'h00);
        bus.address = P_STAT;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_regs", {bank, cursor_x}, 16'h0000);
        check("mid_rst_misc", {videomode, 6'b0, kbd_shift, kbd_irq}, 16'h0000);
        check("mid_rst_status", bus.data_i, 8'h00);
        #3 reset = 1'b0;
        tick();

        q.delete(); m_ovf = 0; m_brk = 0; m_shift = 0; m_ien = 0;
        for (int c = 0; c < 800; c++) begin
            wr_r = $urandom_range(0, 7) == 0;
            dat_r = 8'($urandom);
            if ($urandom_range(0, 15) != 0) dat_r[4] = 1'b0;
            rd_r = !wr_r && $urandom_range(0, 2) == 0;
            hit_r = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 9))
                0: code_r = 8'hF0;
                1: code_r = 8'hE0;
                2: code_r = 8'h12;
                3: code_r = 8'h59;
                default: code_r = 8'($urandom);
            endcase
            asc_r = 8'($urandom);
            bus.address = wr_r ? P_STAT : P_KEYB; bus.wren = wr_r; bus.rden = rd_r; bus.data_o = dat_r;
            ps2_hit = hit_r; ps2_data = code_r; kbd_ascii = asc_r;
            #1;
            exp8 = wr_r ? {m_ovf, m_ien, q.size() == D, q.size() != 0, (q.size() > 15) ? 4'hF : 4'(q.size())}
                        : (q.size() != 0 ? 8'(q[0]) : 8'h00);
            check("rnd_read", bus.data_i, exp8);
            m_irq = m_ien && q.size() != 0;
            if (wr_r && dat_r[7]) m_ovf = 0;
            if (wr_r && dat_r[4]) q.delete();
            else begin
                pop_r = rd_r && q.size() != 0;
                if (pop_r) void'(q.pop_front());
                if (hit_r && code_r != 8'hF0 && code_r != 8'hE0) begin
                    if (q.size() < D) q.push_back({m_brk, asc_r[6:0]});
                    else m_ovf = 1;
                end
            end
`ifdef KBD_IRQ_EN
            if (wr_r) m_ien = dat_r[6];
`endif
            if (hit_r && (code_r == 8'h12 || code_r == 8'h59)) m_shift = !m_brk;
            if (hit_r && code_r != 8'hE0) m_brk = code_r == 8'hF0;
            tick();
            check("rnd_shift", kbd_shift, m_shift);
            check("rnd_irq", kbd_irq, m_irq);
        end
        bus.wren = 1'b0; bus.rden = 1'b0; ps2_hit = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
